// File: rtl/mac_vert_pkg.sv
// Shared widths and FSM state encoding for the self-sequencing vertical bit-column MAC.
package mac_vert_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SUM   = 3'd1,
    ST_COL   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int sel_w(input int group_size);
    return $clog2(group_size + 1);
  endfunction

  function automatic int gsum_w(input int data_width, input int group_size);
    return data_width + $clog2(group_size);
  endfunction

  function automatic int tsum_w(input int data_width, input int vec_length);
    return data_width + $clog2(vec_length);
  endfunction

endpackage

// File: rtl/mac_unit_vert_seq_group_select_sum.sv
// One lane group: GROUP_SIZE/2 lane muxes, their sum, and the skip-zero term select.
module group_select_sum
  import mac_vert_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int GROUP_SIZE = 8,
  parameter int SEL_W      = sel_w(GROUP_SIZE),
  parameter int GSUM_W     = gsum_w(DATA_WIDTH, GROUP_SIZE),
  parameter int TERM_W     = GSUM_W + 1
) (
  input  logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0] act_grp,
  input  logic [GROUP_SIZE/2-1:0][SEL_W-1:0]    sel,
  input  logic                                  skip_zero,
  input  logic signed [GSUM_W-1:0]              group_sum,
  output logic signed [TERM_W-1:0]              term
);

  logic signed [TERM_W-1:0] psum;
  logic [DATA_WIDTH-1:0]    lane;

  // A lane may be picked by several selects, so psum and the difference need one extra bit.
  always_comb begin
    psum = '0;
    lane = '0;
    for (int i = 0; i < GROUP_SIZE / 2; i++) begin
      lane = '0;
      for (int k = 1; k <= GROUP_SIZE; k++) begin
        if (sel[i] == SEL_W'(k)) lane = act_grp[k-1];
      end
      psum = psum + TERM_W'($signed(lane));
    end
    term = skip_zero ? psum : (TERM_W'(group_sum) - psum);
  end

endmodule

// File: rtl/mac_unit_vert_seq.sv
// Self-sequencing vertical bit-column MAC: load a job, walk W_BITS weight columns, deliver one result.
//   state    | meaning
//   ST_IDLE  | act_ready high, waiting for a job
//   ST_SUM   | register per-group and total activation sums
//   ST_COL   | col_ready high, one beat per weight-bit column
//   ST_DRAIN | let the two-stage accumulate pipe empty
//   ST_DONE  | out_valid high until out_ready
module mac_unit_vert_seq
  import mac_vert_pkg::*;
#(
  parameter int  DATA_WIDTH   = 8,
  parameter int  VEC_LENGTH   = 32,
  parameter int  GROUP_SIZE   = 8,
  parameter int  W_BITS       = 8,
  parameter int  ACC_WIDTH    = DATA_WIDTH + 16,
  parameter int  RESULT_WIDTH = 2 * DATA_WIDTH,
  localparam int NUM_GROUPS   = VEC_LENGTH / GROUP_SIZE,
  localparam int SEL_W        = sel_w(GROUP_SIZE)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   act_valid,
  output logic                                   act_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  act_in,
  input  logic                                   load_accum,
  input  logic                                   is_pooling,
  input  logic [RESULT_WIDTH-1:0]                result_prev,
  input  logic                                   col_valid,
  output logic                                   col_ready,
  input  logic [VEC_LENGTH/2-1:0][SEL_W-1:0]     act_sel,
  input  logic [NUM_GROUPS-1:0]                  is_skip_zero,
  input  logic [2:0]                             mul_const,
  input  logic                                   is_shift_mul,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [RESULT_WIDTH-1:0]                result
);

  localparam int GSUM_W = gsum_w(DATA_WIDTH, GROUP_SIZE);
  localparam int TSUM_W = tsum_w(DATA_WIDTH, VEC_LENGTH);
  localparam int TERM_W = GSUM_W + 1;
  localparam int CNT_W  = (W_BITS > 1) ? $clog2(W_BITS) : 1;
  localparam int HALF_G = GROUP_SIZE / 2;

  state_e                                state_q, state_d;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] acts_q, acts_d;
  logic                                  pool_q, pool_d;
  logic signed [RESULT_WIDTH-1:0]        prev_q, prev_d;
  logic signed [ACC_WIDTH-1:0]           acc_q, acc_d;
  logic signed [GSUM_W-1:0]              gsum_q [NUM_GROUPS];
  logic signed [GSUM_W-1:0]              gsum_d [NUM_GROUPS];
  logic signed [TSUM_W-1:0]              tsum_q, tsum_d;
  logic [CNT_W-1:0]                      col_cnt_q, col_cnt_d;
  logic                                  s1_val_q, s1_val_d;
  logic signed [ACC_WIDTH-1:0]           s1_t_q, s1_t_d;
  logic signed [ACC_WIDTH-1:0]           s1_m_q, s1_m_d;
  logic                                  s2_val_q, s2_val_d;
  logic [RESULT_WIDTH-1:0]               result_q, result_d;

  logic signed [GSUM_W-1:0]       gsum_calc [NUM_GROUPS];
  logic signed [TSUM_W-1:0]       tsum_calc;
  logic signed [TERM_W-1:0]       term [NUM_GROUPS];
  logic signed [ACC_WIDTH-1:0]    t_sum, t_col, t_shift, m_term;
  logic signed [RESULT_WIDTH-1:0] acc_slice;
  logic [RESULT_WIDTH-1:0]        pool_out;
  logic                           last_col;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    group_select_sum #(
      .DATA_WIDTH (DATA_WIDTH),
      .GROUP_SIZE (GROUP_SIZE)
    ) u_grp (
      .act_grp   (acts_q[g*GROUP_SIZE +: GROUP_SIZE]),
      .sel       (act_sel[g*HALF_G +: HALF_G]),
      .skip_zero (is_skip_zero[g]),
      .group_sum (gsum_q[g]),
      .term      (term[g])
    );
  end

  always_comb begin
    gsum_calc = '{default: '0};
    tsum_calc = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      for (int i = 0; i < GROUP_SIZE; i++) begin
        gsum_calc[g] = gsum_calc[g] + GSUM_W'($signed(acts_q[g*GROUP_SIZE+i]));
      end
      tsum_calc = tsum_calc + TSUM_W'(gsum_calc[g]);
    end
  end

  // Column W_BITS-1 carries the negative weight of the two's-complement weight bits.
  always_comb begin
    t_sum = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      t_sum = t_sum + ACC_WIDTH'(term[g]);
    end
    last_col = (col_cnt_q == CNT_W'(W_BITS - 1));
    t_col    = last_col ? -t_sum : t_sum;
    t_shift  = t_col <<< col_cnt_q;
    m_term   = ACC_WIDTH'(tsum_q) * ACC_WIDTH'($signed({1'b0, mul_const}));
    if (is_shift_mul) m_term = m_term <<< 3;
  end

  always_comb begin
    acc_slice = acc_q[ACC_WIDTH-1 -: RESULT_WIDTH];
    pool_out  = (pool_q && (prev_q > acc_slice)) ? prev_q : acc_slice;
  end

  always_comb begin
    state_d   = state_q;
    acts_d    = acts_q;
    pool_d    = pool_q;
    prev_d    = prev_q;
    acc_d     = acc_q;
    gsum_d    = gsum_q;
    tsum_d    = tsum_q;
    col_cnt_d = col_cnt_q;
    s1_val_d  = 1'b0;
    s1_t_d    = s1_t_q;
    s1_m_d    = s1_m_q;
    s2_val_d  = s1_val_q;
    result_d  = result_q;

    if (s1_val_q) acc_d = acc_q + s1_t_q + s1_m_q;

    case (state_q)
      ST_IDLE: begin
        if (act_valid) begin
          acts_d  = act_in;
          pool_d  = is_pooling;
          prev_d  = result_prev;
          acc_d   = load_accum ?
                    (ACC_WIDTH'($signed(result_prev)) <<< (ACC_WIDTH - RESULT_WIDTH)) : '0;
          state_d = ST_SUM;
        end
      end
      ST_SUM: begin
        gsum_d    = gsum_calc;
        tsum_d    = tsum_calc;
        col_cnt_d = '0;
        state_d   = ST_COL;
      end
      ST_COL: begin
        if (col_valid) begin
          s1_val_d  = 1'b1;
          s1_t_d    = t_shift;
          s1_m_d    = m_term;
          col_cnt_d = col_cnt_q + CNT_W'(1);
          if (last_col) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!s1_val_q && !s2_val_q) begin
          result_d = pool_out;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      acts_q    <= '0;
      pool_q    <= 1'b0;
      prev_q    <= '0;
      acc_q     <= '0;
      for (int g = 0; g < NUM_GROUPS; g++) gsum_q[g] <= '0;
      tsum_q    <= '0;
      col_cnt_q <= '0;
      s1_val_q  <= 1'b0;
      s1_t_q    <= '0;
      s1_m_q    <= '0;
      s2_val_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      acts_q    <= acts_d;
      pool_q    <= pool_d;
      prev_q    <= prev_d;
      acc_q     <= acc_d;
      gsum_q    <= gsum_d;
      tsum_q    <= tsum_d;
      col_cnt_q <= col_cnt_d;
      s1_val_q  <= s1_val_d;
      s1_t_q    <= s1_t_d;
      s1_m_q    <= s1_m_d;
      s2_val_q  <= s2_val_d;
      result_q  <= result_d;
    end
  end

  assign act_ready = (state_q == ST_IDLE);
  assign col_ready = (state_q == ST_COL);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_mac_unit_vert_seq.sv
// Directed and randomized jobs for mac_unit_vert_seq against an arithmetic reference model.
module tb_mac_unit_vert_seq;

  localparam int DW  = 8;
  localparam int VL  = 32;
  localparam int GS  = 8;
  localparam int WB  = 8;
  localparam int ACW = DW + 16;
  localparam int RW  = 2 * DW;
  localparam int NG  = VL / GS;
  localparam int SW  = 4;
  localparam int NS  = VL / 2;

  logic                   clk;
  logic                   reset;
  logic                   act_valid;
  logic                   act_ready;
  logic [VL-1:0][DW-1:0]  act_in;
  logic                   load_accum;
  logic                   is_pooling;
  logic [RW-1:0]          result_prev;
  logic                   col_valid;
  logic                   col_ready;
  logic [NS-1:0][SW-1:0]  act_sel;
  logic [NG-1:0]          is_skip_zero;
  logic [2:0]             mul_const;
  logic                   is_shift_mul;
  logic                   out_valid;
  logic                   out_ready;
  logic [RW-1:0]          result;

  int n_checks = 0;
  int n_fail   = 0;

  // job description used by both the driver and the reference model
  int          act_vals [VL];
  int          col_sel  [WB][NS];
  logic [NG-1:0] col_skip [WB];
  int          col_mul  [WB];
  logic        col_shift[WB];
  logic        job_load;
  logic        job_pool;
  int          job_prev;

  mac_unit_vert_seq dut (
    .clk          (clk),
    .reset        (reset),
    .act_valid    (act_valid),
    .act_ready    (act_ready),
    .act_in       (act_in),
    .load_accum   (load_accum),
    .is_pooling   (is_pooling),
    .result_prev  (result_prev),
    .col_valid    (col_valid),
    .col_ready    (col_ready),
    .act_sel      (act_sel),
    .is_skip_zero (is_skip_zero),
    .mul_const    (mul_const),
    .is_shift_mul (is_shift_mul),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial weights: column c has weight 2^c, the top column has weight -2^(WB-1).
  function automatic logic [RW-1:0] model_result();
    longint acc, t, gsum, psum, total, m;
    logic [63:0] bits;
    logic [RW-1:0] r;
    int s;
    total = 0;
    for (int l = 0; l < VL; l++) total += act_vals[l];
    acc = job_load ? longint'(job_prev) * (longint'(1) << (ACW - RW)) : 0;
    for (int c = 0; c < WB; c++) begin
      t = 0;
      for (int g = 0; g < NG; g++) begin
        gsum = 0;
        psum = 0;
        for (int i = 0; i < GS; i++) gsum += act_vals[g*GS+i];
        for (int i = 0; i < GS / 2; i++) begin
          s = col_sel[c][g*(GS/2)+i];
          if (s >= 1 && s <= GS) psum += act_vals[g*GS+s-1];
        end
        t += col_skip[c][g] ? psum : gsum - psum;
      end
      if (c == WB - 1) t = -t;
      m = total * col_mul[c] * (col_shift[c] ? 8 : 1);
      acc += t * (longint'(1) << c) + m;
    end
    bits = acc;
    r = bits[ACW-1 -: RW];
    if (job_pool && job_prev > int'($signed(r))) r = RW'(job_prev);
    return r;
  endfunction

  task automatic set_uniform(input int a, input int sel, input logic skip, input int mul,
                             input logic shift, input logic ld, input logic pool, input int prev);
    for (int l = 0; l < VL; l++) act_vals[l] = a;
    for (int c = 0; c < WB; c++) begin
      for (int i = 0; i < NS; i++) col_sel[c][i] = sel;
      col_skip[c]  = {NG{skip}};
      col_mul[c]   = mul;
      col_shift[c] = shift;
    end
    job_load = ld;
    job_pool = pool;
    job_prev = prev;
  endtask

  task automatic set_random();
    for (int l = 0; l < VL; l++) act_vals[l] = int'($urandom_range(0, 255)) - 128;
    for (int c = 0; c < WB; c++) begin
      for (int i = 0; i < NS; i++) col_sel[c][i] = int'($urandom_range(0, 15));
      col_skip[c]  = NG'($urandom_range(0, 15));
      col_mul[c]   = int'($urandom_range(0, 7));
      col_shift[c] = 1'($urandom_range(0, 1));
    end
    job_load = 1'($urandom_range(0, 1));
    job_pool = 1'($urandom_range(0, 1));
    job_prev = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic accept_job();
    int n = 0;
    for (int l = 0; l < VL; l++) act_in[l] = DW'(act_vals[l]);
    load_accum  = job_load;
    is_pooling  = job_pool;
    result_prev = RW'(job_prev);
    act_valid   = 1'b1;
    while (!act_ready && n < 50) begin @(negedge clk); n++; end
    chk("act_accept_wait", 32'(n < 50), 32'd1);
    @(negedge clk);
    act_valid   = 1'b0;
    act_in      = '0;
    result_prev = '0;
    load_accum  = 1'b0;
    is_pooling  = 1'b0;
  endtask

  task automatic do_beat(input int c, input int gap);
    int n = 0;
    col_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      act_sel = NS*SW'($urandom());
      @(negedge clk);
    end
    for (int i = 0; i < NS; i++) act_sel[i] = SW'(col_sel[c][i]);
    is_skip_zero = col_skip[c];
    mul_const    = 3'(col_mul[c]);
    is_shift_mul = col_shift[c];
    col_valid    = 1'b1;
    while (!col_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("col_ready_wait", 32'd0, 32'd1);
    @(negedge clk);
    col_valid = 1'b0;
  endtask

  task automatic finish_job(input int hold, input logic [RW-1:0] exp, input string tag);
    int n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk(tag, 32'(result), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      act_valid = 1'b1;
      col_valid = 1'b1;
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_result", 32'(result), 32'(exp));
      chk("hold_act_ready", 32'(act_ready), 32'd0);
      chk("hold_col_ready", 32'(col_ready), 32'd0);
    end
    act_valid = 1'b0;
    col_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_after_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_after_act_ready"}, 32'(act_ready), 32'd1);
  endtask

  task automatic run_job(input int gmin, input int gmax, input int hold,
                         input logic [RW-1:0] exp, input string tag);
    accept_job();
    for (int c = 0; c < WB; c++) do_beat(c, int'($urandom_range(gmin, gmax)));
    finish_job(hold, exp, tag);
  endtask

  initial begin
    reset        = 1'b0;
    act_valid    = 1'b0;
    act_in       = '0;
    load_accum   = 1'b0;
    is_pooling   = 1'b0;
    result_prev  = '0;
    col_valid    = 1'b0;
    act_sel      = '0;
    is_skip_zero = '0;
    mul_const    = '0;
    is_shift_mul = 1'b0;
    out_ready    = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_act_ready", 32'(act_ready), 32'd1);
    chk("rst_col_ready", 32'(col_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // T=16 per column; the negative top column leaves -16
    set_uniform(1, 1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0);
    run_job(0, 0, 0, 16'hFFFF, "sel1_skip1");

    // T=32 per column, back-to-back then with gaps
    set_uniform(1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    run_job(0, 0, 0, 16'hFFFF, "sel0_skip0");
    run_job(1, 3, 0, 16'hFFFF, "sel0_skip0_gaps");

    // M = 64*3<<3 = 1536 per beat
    set_uniform(2, 0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 0);
    run_job(0, 0, 0, 16'd48, "mul_shift");

    set_uniform(0, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 5);
    run_job(0, 0, 0, 16'd5, "load_accum");

    set_uniform(1, 1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 100);
    run_job(0, 0, 5, 16'd100, "pool_hold");

    // abort during column 3
    set_random();
    accept_job();
    for (int c = 0; c < 3; c++) do_beat(c, 0);
    col_valid = 1'b1;
    reset     = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_act_ready", 32'(act_ready), 32'd1);
    chk("midrst_col_ready", 32'(col_ready), 32'd0);
    reset     = 1'b1;
    col_valid = 1'b0;
    @(negedge clk);
    chk("postrst_act_ready", 32'(act_ready), 32'd1);
    chk("postrst_result", 32'(result), 32'd0);

    set_uniform(1, 1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0);
    run_job(0, 0, 0, 16'hFFFF, "postrst_job");

    for (int j = 0; j < 12; j++) begin
      set_random();
      run_job(0, 3, (j % 3 == 0) ? 2 : 0, model_result(), "random_job");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
